// File: rtl/rc5_pkg.sv
// Shared widths, FSM encoding and captured-request layout for the RC5 core scheduler.
package rc5_pkg;
  localparam int KEY_W = 128;
  localparam int BLK_W = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_LOAD, S_KEY_ARM, S_KEY_WAIT, S_DATA, S_RES_WAIT
  } state_t;

  typedef struct packed {
    logic             ch;
    logic             flag;
    logic [KEY_W-1:0] key;
    logic [BLK_W-1:0] din;
  } req_t;
endpackage

// File: rtl/rc5_rr_arb.sv
// Two-requester round-robin arbiter; the pointer only moves when a grant is taken.
module rc5_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_vld,
  input  logic       i_adv,
  output logic [1:0] o_grant
);
  logic r_last;  // 1: ch1 was granted last

  always_comb begin
    o_grant = i_vld;
    if (&i_vld) o_grant = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_last <= 1'b1;
    else if (i_adv) r_last <= o_grant[1];
  end
endmodule

// File: rtl/rc5_sched.sv
// Shares one rc5_core between two channels: round-robin accept, cached key expansion,
// din sequencing, result return and wait-state timeout.
module rc5_sched
  import rc5_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ch0_vld,
  output logic             o_ch0_rdy,
  input  logic             i_ch0_flag,
  input  logic [KEY_W-1:0] i_ch0_key,
  input  logic [BLK_W-1:0] i_ch0_din,
  output logic [BLK_W-1:0] o_ch0_dout,
  output logic             o_ch0_dout_en,
  output logic             o_ch0_err,
  input  logic             i_ch1_vld,
  output logic             o_ch1_rdy,
  input  logic             i_ch1_flag,
  input  logic [KEY_W-1:0] i_ch1_key,
  input  logic [BLK_W-1:0] i_ch1_din,
  output logic [BLK_W-1:0] o_ch1_dout,
  output logic             o_ch1_dout_en,
  output logic             o_ch1_err,
  output logic             o_core_flag,
  output logic [KEY_W-1:0] o_core_key,
  output logic             o_core_key_en,
  output logic [BLK_W-1:0] o_core_din,
  output logic             o_core_din_en,
  input  logic [BLK_W-1:0] i_core_dout,
  input  logic             i_core_dout_en,
  input  logic             i_core_key_ok,
  output logic             o_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           r_state, w_next;
  req_t             r_req, w_req;
  logic [KEY_W-1:0] r_cur_key;
  logic             r_key_vld;
  logic [CW-1:0]    r_cnt;
  logic [BLK_W-1:0] r_dout0, r_dout1;
  logic             r_dout_en0, r_dout_en1;
  logic [1:0]       w_grant;
  logic             w_acc, w_hit, w_wait, w_done, w_kok, w_to;

  rc5_rr_arb u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vld   ({i_ch1_vld, i_ch0_vld}),
    .i_adv   (w_acc),
    .o_grant (w_grant)
  );

  always_comb begin
    w_req.ch   = w_grant[1];
    w_req.flag = w_grant[1] ? i_ch1_flag : i_ch0_flag;
    w_req.key  = w_grant[1] ? i_ch1_key  : i_ch0_key;
    w_req.din  = w_grant[1] ? i_ch1_din  : i_ch0_din;
  end

  assign w_acc  = (r_state == S_IDLE) & (|w_grant);
  assign w_hit  = r_key_vld & (w_req.key == r_cur_key);
  assign w_wait = (r_state == S_KEY_WAIT) | (r_state == S_RES_WAIT);
  assign w_done = (r_state == S_RES_WAIT) & i_core_dout_en;
  assign w_kok  = (r_state == S_KEY_WAIT) & i_core_key_ok;
  // A completion arriving on the expiry cycle beats the timeout.
  assign w_to   = w_wait & (r_cnt == CW'(TIMEOUT)) & ~w_done & ~w_kok;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_acc) w_next = w_hit ? S_DATA : S_KEY_LOAD;
      S_KEY_LOAD: w_next = S_KEY_ARM;
      S_KEY_ARM:  w_next = S_KEY_WAIT;
      S_KEY_WAIT: if (w_kok) w_next = S_DATA; else if (w_to) w_next = S_IDLE;
      S_DATA:     w_next = S_RES_WAIT;
      S_RES_WAIT: if (w_done | w_to) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ch0_rdy     = (r_state == S_IDLE) & w_grant[0];
    o_ch1_rdy     = (r_state == S_IDLE) & w_grant[1];
    o_core_key_en = (r_state == S_KEY_LOAD);
    o_core_din_en = (r_state == S_DATA);
    o_busy        = (r_state != S_IDLE);
    o_ch0_err     = w_to & ~r_req.ch;
    o_ch1_err     = w_to &  r_req.ch;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req      <= '0;
      r_cur_key  <= '0;
      r_key_vld  <= 1'b0;
      r_cnt      <= '0;
      r_dout0    <= '0;
      r_dout1    <= '0;
      r_dout_en0 <= 1'b0;
      r_dout_en1 <= 1'b0;
    end else begin
      r_dout_en0 <= w_done & ~r_req.ch;
      r_dout_en1 <= w_done &  r_req.ch;
      if (w_done & ~r_req.ch) r_dout0 <= i_core_dout;
      if (w_done &  r_req.ch) r_dout1 <= i_core_dout;
      if (w_acc) r_req <= w_req;
      if (r_state == S_KEY_LOAD) begin
        r_cur_key <= r_req.key;
        r_key_vld <= 1'b0;
      end else if (w_kok) begin
        r_key_vld <= 1'b1;
      end else if (w_to) begin
        r_key_vld <= 1'b0;
      end
      if (w_next != r_state) r_cnt <= '0;
      else if (w_wait)       r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_core_flag   = r_req.flag;
  assign o_core_key    = r_req.key;
  assign o_core_din    = r_req.din;
  assign o_ch0_dout    = r_dout0;
  assign o_ch1_dout    = r_dout1;
  assign o_ch0_dout_en = r_dout_en0;
  assign o_ch1_dout_en = r_dout_en1;
endmodule

// File: tb/tb_rc5_sched.sv
// Directed bench for rc5_sched behind a behavioural core stand-in (fixed key/data latencies).
module tb_rc5_sched;
  localparam logic [127:0] KEY1 = 128'h915f4619be41b2516355a50110a9ce91;
  localparam logic [127:0] KEY2 = KEY1 ^ 128'h1;
  localparam logic [63:0]  PT1  = 64'h21a5dbee154b8f6d;
  localparam logic [63:0]  CT1  = 64'hf7c013ac5b2b8952;
  localparam logic [63:0]  PT1K2 = 64'h42f07eef05e241fd;  // PT1 ^ KEY2[63:0]
  // Stand-in core: key_ok returns at c=7 after accept, so a miss issues din_en at c=8.
  localparam int MISS_DIN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] vld, fl;
  logic [127:0] key0, key1;
  logic [63:0] din0, din1;
  logic rdy0, rdy1, de0, de1, er0, er1, busy;
  logic [63:0] dout0, dout1;
  logic core_flag, core_key_en, core_din_en, core_dout_en, core_key_ok;
  logic [127:0] core_key;
  logic [63:0] core_din, core_dout;
  logic stall, inj;
  logic [63:0] inj_dout;

  rc5_sched #(.TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ch0_vld(vld[0]), .o_ch0_rdy(rdy0), .i_ch0_flag(fl[0]), .i_ch0_key(key0), .i_ch0_din(din0),
    .o_ch0_dout(dout0), .o_ch0_dout_en(de0), .o_ch0_err(er0),
    .i_ch1_vld(vld[1]), .o_ch1_rdy(rdy1), .i_ch1_flag(fl[1]), .i_ch1_key(key1), .i_ch1_din(din1),
    .o_ch1_dout(dout1), .o_ch1_dout_en(de1), .o_ch1_err(er1),
    .o_core_flag(core_flag), .o_core_key(core_key), .o_core_key_en(core_key_en),
    .o_core_din(core_din), .o_core_din_en(core_din_en),
    .i_core_dout(core_dout), .i_core_dout_en(core_dout_en), .i_core_key_ok(core_key_ok),
    .o_busy(busy)
  );

  function automatic logic [63:0] stub_f(input logic [127:0] k, input logic f, input logic [63:0] d);
    if (k == KEY1 && f && d == PT1)  return CT1;
    if (k == KEY1 && !f && d == CT1) return PT1;
    return d ^ k[63:0];
  endfunction

  // Core stand-in: key_ok drops one cycle after key_en is sampled, then rises later;
  // the result uses the key that was actually loaded, not the current key lines.
  logic m_key_ok, m_drop, m_dout_en;
  logic [2:0] m_kcnt, m_dcnt;
  logic [127:0] m_key;
  logic [63:0] m_res, m_dout;
  always @(posedge clk) begin
    if (rst) begin
      m_key_ok <= 0; m_drop <= 0; m_kcnt <= 0; m_dcnt <= 0;
      m_dout_en <= 0; m_dout <= 0; m_key <= 0; m_res <= 0;
    end else begin
      m_drop <= core_key_en;
      m_dout_en <= 0;
      if (m_kcnt != 0) m_kcnt <= m_kcnt - 1;
      if (core_key_en) begin m_key <= core_key; m_kcnt <= 5; end
      if (m_drop) m_key_ok <= 0;
      else if (m_kcnt == 1) m_key_ok <= 1;
      if (m_dcnt != 0) m_dcnt <= m_dcnt - 1;
      if (m_dcnt == 1 && !stall) begin m_dout_en <= 1; m_dout <= m_res; end
      if (core_din_en) begin m_dcnt <= 3; m_res <= stub_f(m_key, core_flag, core_din); end
    end
  end
  assign core_key_ok  = m_key_ok;
  assign core_dout_en = m_dout_en | inj;
  assign core_dout    = inj ? inj_dout : m_dout;

  int nkey = 0, nstrb = 0;
  always @(negedge clk) begin
    if (core_key_en) nkey++;
    if (de0 | de1 | er0 | er1) nstrb++;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; vld = 0; stall = 0; inj = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic drive(input bit ch, input bit f, input logic [127:0] k, input logic [63:0] d);
    if (ch) begin key1 = k; din1 = d; end
    else    begin key0 = k; din0 = d; end
    fl[ch] = f; vld[ch] = 1'b1;
  endtask

  // Issue one request and follow it; cycle c=1 is the cycle after the accepting edge.
  task automatic do_req(input bit ch, input bit f, input logic [127:0] k, input logic [63:0] d,
                        output logic [63:0] res, output int din_c, output int got, output int err_c);
    int w;
    @(negedge clk);
    drive(ch, f, k, d);
    #1; w = 0;
    while (!(ch ? rdy1 : rdy0) && w < 50) begin @(negedge clk); #1; w++; end
    chk("accept", ch ? rdy1 : rdy0, 1);
    @(negedge clk);
    vld[ch] = 1'b0;
    res = '0; din_c = 0; got = 0; err_c = 0;
    for (int i = 1; i < 60; i++) begin
      if (core_din_en && din_c == 0) din_c = i;
      if (ch ? er1 : er0) begin err_c = i; break; end
      if (ch ? de1 : de0) begin res = ch ? dout1 : dout0; got = i; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit ch; bit fl; logic [127:0] key; logic [63:0] din; logic [63:0] exp; bit load;
  } vec_t;
  vec_t tv[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] res, oth;
    int dc, got, ec, nk0, ns0, w;
    bit ec_ch;

    tv[0] = '{0, 1, KEY1, PT1, CT1,   1};
    tv[1] = '{1, 0, KEY1, CT1, PT1,   0};
    tv[2] = '{0, 1, KEY1, PT1, CT1,   0};
    tv[3] = '{1, 1, KEY2, PT1, PT1K2, 1};
    tv[4] = '{0, 1, KEY1, PT1, CT1,   1};
    tv[5] = '{0, 0, KEY1, CT1, PT1,   0};

    rst = 1; vld = 0; fl = 0; key0 = 0; key1 = 0; din0 = 0; din1 = 0;
    stall = 0; inj = 0; inj_dout = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, core_key_en, core_din_en, rdy1, rdy0, de1, de0, er1, er0, core_flag}, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_douts", {dout1, dout0}, 0);
    rst = 0;

    // Single-channel sequence: cold load, hit across channels, key thrash, hit again.
    for (int i = 0; i < 6; i++) begin
      nk0 = nkey; ns0 = nstrb;
      oth = tv[i].ch ? dout0 : dout1;
      do_req(tv[i].ch, tv[i].fl, tv[i].key, tv[i].din, res, dc, got, ec);
      chk($sformatf("v%0d_dout", i), res, tv[i].exp);
      chk($sformatf("v%0d_done", i), got != 0, 1);
      chk($sformatf("v%0d_keyloads", i), nkey - nk0, tv[i].load);
      chk($sformatf("v%0d_din_cycle", i), dc, tv[i].load ? MISS_DIN : 1);
      chk($sformatf("v%0d_err", i), ec, 0);
      @(negedge clk); #1;
      chk($sformatf("v%0d_pulse_len", i), tv[i].ch ? de1 : de0, 0);
      chk($sformatf("v%0d_other_hold", i), tv[i].ch ? dout0 : dout1, oth);
      chk($sformatf("v%0d_strobes", i), nstrb - ns0, 1);
    end

    // Stray core result while idle must be ignored.
    ns0 = nstrb; oth = dout0;
    @(negedge clk); inj_dout = 64'hdeadbeefcafef00d; inj = 1;
    @(negedge clk); inj = 0;
    repeat (2) @(negedge clk); #1;
    chk("stray_strobes", nstrb - ns0, 0);
    chk("stray_hold", dout0, oth);
    chk("stray_busy", busy, 0);

    // Both channels valid from reset: ch0 first, strict alternation, single key load.
    do_reset();
    nk0 = nkey;
    @(negedge clk);
    drive(0, 1, KEY1, PT1);
    drive(1, 0, KEY1, CT1);
    for (int i = 0; i < 16; i++) begin
      #1; w = 0;
      while (!(rdy0 | rdy1) && w < 60) begin @(negedge clk); #1; w++; end
      chk($sformatf("rr%0d_grant", i), {rdy1, rdy0}, (i % 2) ? 2'b10 : 2'b01);
      ec_ch = (i % 2) != 0;
      @(negedge clk); w = 0;
      while (!(ec_ch ? de1 : de0) && w < 60) begin @(negedge clk); w++; end
      chk($sformatf("rr%0d_dout", i), ec_ch ? dout1 : dout0, ec_ch ? PT1 : CT1);
      if (i == 15) vld = 0;
    end
    #1;
    chk("rr_keyloads", nkey - nk0, 1);

    // Result never returns: error strobe 16 cycles into RES_WAIT, key cache dropped.
    @(negedge clk); stall = 1;
    ns0 = nstrb;
    do_req(0, 1, KEY1, PT1, res, dc, got, ec);
    chk("to_din_cycle", dc, 1);
    chk("to_err_cycle", ec, 18);
    chk("to_no_dout", got, 0);
    @(negedge clk); #1;
    chk("to_err_len", er0, 0);
    chk("to_strobes", nstrb - ns0, 1);
    stall = 0;
    nk0 = nkey;
    do_req(0, 1, KEY1, PT1, res, dc, got, ec);
    chk("to_reload_keys", nkey - nk0, 1);
    chk("to_reload_dout", res, CT1);

    // Reset during KEY_WAIT drops the request and invalidates the cache.
    @(negedge clk);
    drive(0, 1, KEY2, PT1);
    #1; chk("rk_accept", rdy0, 1);
    @(negedge clk); vld[0] = 0;
    chk("rk_key_en", core_key_en, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rk_ctrl", {busy, core_key_en, core_din_en, rdy1, rdy0, de1, de0, er1, er0, core_flag}, 0);
    chk("rk_core_key", core_key, 0);
    chk("rk_core_din", core_din, 0);
    chk("rk_douts", {dout1, dout0}, 0);
    rst = 0;
    ns0 = nstrb;
    repeat (12) @(negedge clk); #1;
    chk("rk_no_strobe", nstrb - ns0, 0);
    nk0 = nkey;
    do_req(0, 1, KEY1, PT1, res, dc, got, ec);
    chk("rk_reload_keys", nkey - nk0, 1);
    chk("rk_din_cycle", dc, MISS_DIN);
    chk("rk_dout", res, CT1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
